// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer and its users (RS, SLB sizing).
// Entry layout and pointer/counter widths live here.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PTR_W     = $clog2(ROB_DEPTH);
    localparam int PC_W      = 32;
    localparam int DATA_W    = 32;
    localparam int RD_W      = 5;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              is_store;
        logic              mispredict;
        logic [RD_W-1:0]   rd;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   target;
    } entry_t;

endpackage

// File: rtl/rob_tag_match.sv
// Oldest-first pc tag match over busy, not-ready entries.
// Priority rotates with head so the earliest allocated duplicate tag wins.
module rob_tag_match
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_DEPTH-1:0]           busy,
    input  logic [ROB_DEPTH-1:0]           ready,
    input  logic [ROB_DEPTH-1:0][PC_W-1:0] pcs,
    input  ptr_t                           head,
    input  logic                           valid,
    input  logic [PC_W-1:0]                tag,
    output logic                           hit,
    output ptr_t                           idx
);

    ptr_t j;

    // Descending scan: the last assignment is the entry closest to head.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
            j = head + ptr_t'(i);
            if (valid && busy[j] && !ready[j] && pcs[j] == tag) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates on issue, captures ALU/SLB results,
// retires from head to the register file and flushes on a mispredicted head.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              is_empty_from_decoder,
    input  logic [PC_W-1:0]   pc_from_decoder,
    input  logic [RD_W-1:0]   rd_from_decoder,
    input  logic              is_store_from_decoder,
    input  logic              is_finish_from_alu,
    input  logic [PC_W-1:0]   pc_from_alu,
    input  logic [DATA_W-1:0] data_from_alu,
    input  logic              is_mispredict_from_alu,
    input  logic [PC_W-1:0]   target_from_alu,
    input  logic              is_finish_from_slb,
    input  logic [PC_W-1:0]   pc_from_slb,
    input  logic [DATA_W-1:0] data_from_slb,
    output logic              is_full_to_decoder,
    output logic              is_commit_to_rf,
    output logic              is_exception_to_rf,
    output logic [PC_W-1:0]   pc_to_rf,
    output logic [RD_W-1:0]   rd_to_rf,
    output logic [DATA_W-1:0] data_to_rf,
    output logic              is_commit_store_to_slb,
    output logic [PC_W-1:0]   pc_to_slb,
    output logic [PC_W-1:0]   target_pc_to_if
);

    entry_t rob [ROB_DEPTH];
    ptr_t   head;
    ptr_t   tail;
    cnt_t   count;

    logic [ROB_DEPTH-1:0]           busy_v;
    logic [ROB_DEPTH-1:0]           ready_v;
    logic [ROB_DEPTH-1:0][PC_W-1:0] pc_v;

    entry_t head_e;
    logic   full;
    logic   issue;
    logic   commit;
    logic   flush;
    logic   alu_hit;
    logic   slb_hit;
    ptr_t   alu_idx;
    ptr_t   slb_idx;

    always_comb begin
        busy_v  = '0;
        ready_v = '0;
        pc_v    = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            busy_v[i]  = rob[i].busy;
            ready_v[i] = rob[i].ready;
            pc_v[i]    = rob[i].pc;
        end
    end

    assign head_e = rob[head];
    assign full   = count == cnt_t'(ROB_DEPTH);
    assign commit = head_e.busy && head_e.ready;
    assign flush  = commit && head_e.mispredict;
    // The cycle after a flush is dead: nothing may allocate or write back.
    assign issue  = !is_empty_from_decoder && !full && !is_exception_to_rf;

    assign is_full_to_decoder = full;

    rob_tag_match u_alu_match (
        .busy  (busy_v),
        .ready (ready_v),
        .pcs   (pc_v),
        .head  (head),
        .valid (is_finish_from_alu && !is_exception_to_rf),
        .tag   (pc_from_alu),
        .hit   (alu_hit),
        .idx   (alu_idx)
    );

    rob_tag_match u_slb_match (
        .busy  (busy_v),
        .ready (ready_v),
        .pcs   (pc_v),
        .head  (head),
        .valid (is_finish_from_slb && !is_exception_to_rf),
        .tag   (pc_from_slb),
        .hit   (slb_hit),
        .idx   (slb_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst && rdy && !is_exception_to_rf)
            assert (is_empty_from_decoder || !full)
            else $warning("rob: issue while full dropped");

        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
            head                   <= '0;
            tail                   <= '0;
            count                  <= '0;
            is_commit_to_rf        <= 1'b0;
            is_exception_to_rf     <= 1'b0;
            pc_to_rf               <= '0;
            rd_to_rf               <= '0;
            data_to_rf             <= '0;
            is_commit_store_to_slb <= 1'b0;
            pc_to_slb              <= '0;
            target_pc_to_if        <= '0;
        end else if (rdy) begin
            is_commit_to_rf        <= commit;
            is_exception_to_rf     <= flush;
            is_commit_store_to_slb <= commit && head_e.is_store;
            if (commit) begin
                pc_to_rf   <= head_e.pc;
                rd_to_rf   <= head_e.rd;
                data_to_rf <= head_e.data;
            end
            if (commit && head_e.is_store) pc_to_slb <= head_e.pc;
            if (flush) target_pc_to_if <= head_e.target;

            if (flush) begin
                for (int i = 0; i < ROB_DEPTH; i++) rob[i].busy <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (slb_hit) begin
                    rob[slb_idx].ready <= 1'b1;
                    rob[slb_idx].data  <= data_from_slb;
                end
                // ALU is applied last so it wins when both hit one entry.
                if (alu_hit) begin
                    rob[alu_idx].ready      <= 1'b1;
                    rob[alu_idx].data       <= data_from_alu;
                    rob[alu_idx].mispredict <= is_mispredict_from_alu;
                    rob[alu_idx].target     <= target_from_alu;
                end
                if (commit) begin
                    rob[head].busy <= 1'b0;
                    head           <= head + ptr_t'(1);
                end
                if (issue) begin
                    rob[tail] <= '{busy: 1'b1, ready: 1'b0,
                                   is_store: is_store_from_decoder,
                                   mispredict: 1'b0,
                                   rd: rd_from_decoder,
                                   pc: pc_from_decoder,
                                   data: '0, target: '0};
                    tail <= tail + ptr_t'(1);
                end
                unique case ({issue, commit})
                    2'b10:   count <= count + cnt_t'(1);
                    2'b01:   count <= count - cnt_t'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retirements are queued at issue
// and compared against each commit the register file would consume.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        is_empty_from_decoder = 1'b1;
    logic [31:0] pc_from_decoder = '0;
    logic [4:0]  rd_from_decoder = '0;
    logic        is_store_from_decoder = 1'b0;
    logic        is_finish_from_alu = 1'b0;
    logic [31:0] pc_from_alu = '0;
    logic [31:0] data_from_alu = '0;
    logic        is_mispredict_from_alu = 1'b0;
    logic [31:0] target_from_alu = '0;
    logic        is_finish_from_slb = 1'b0;
    logic [31:0] pc_from_slb = '0;
    logic [31:0] data_from_slb = '0;
    logic        is_full_to_decoder;
    logic        is_commit_to_rf;
    logic        is_exception_to_rf;
    logic [31:0] pc_to_rf;
    logic [4:0]  rd_to_rf;
    logic [31:0] data_to_rf;
    logic        is_commit_store_to_slb;
    logic [31:0] pc_to_slb;
    logic [31:0] target_pc_to_if;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        st;
        logic        exc;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    reorder_buffer dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .is_empty_from_decoder  (is_empty_from_decoder),
        .pc_from_decoder        (pc_from_decoder),
        .rd_from_decoder        (rd_from_decoder),
        .is_store_from_decoder  (is_store_from_decoder),
        .is_finish_from_alu     (is_finish_from_alu),
        .pc_from_alu            (pc_from_alu),
        .data_from_alu          (data_from_alu),
        .is_mispredict_from_alu (is_mispredict_from_alu),
        .target_from_alu        (target_from_alu),
        .is_finish_from_slb     (is_finish_from_slb),
        .pc_from_slb            (pc_from_slb),
        .data_from_slb          (data_from_slb),
        .is_full_to_decoder     (is_full_to_decoder),
        .is_commit_to_rf        (is_commit_to_rf),
        .is_exception_to_rf     (is_exception_to_rf),
        .pc_to_rf               (pc_to_rf),
        .rd_to_rf               (rd_to_rf),
        .data_to_rf             (data_to_rf),
        .is_commit_store_to_slb (is_commit_store_to_slb),
        .pc_to_slb              (pc_to_slb),
        .target_pc_to_if        (target_pc_to_if)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A commit is consumed by the RF on an edge where rdy is high.
    task automatic consume();
        exp_t e;
        checks++;
        assert (q.size() != 0)
        else begin
            errors++;
            $error("FAIL unexpected_commit: observed pc %h expected none", pc_to_rf);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("commit_pc", pc_to_rf, e.pc);
            chk("commit_rd", 32'(rd_to_rf), 32'(e.rd));
            chk("commit_data", data_to_rf, e.data);
            chk("commit_store", 32'(is_commit_store_to_slb), 32'(e.st));
            chk("commit_exc", 32'(is_exception_to_rf), 32'(e.exc));
            if (e.exc) chk("target_pc", target_pc_to_if, e.tgt);
            if (e.st) chk("store_pc", pc_to_slb, e.pc);
        end
    endtask

    task automatic tick();
        if (rdy && !rst && is_commit_to_rf) consume();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [31:0] pc, logic [4:0] rd, logic st,
                         logic [31:0] data, logic exc, logic [31:0] tgt,
                         logic expect_it);
        exp_t e;
        is_empty_from_decoder = 1'b0;
        pc_from_decoder       = pc;
        rd_from_decoder       = rd;
        is_store_from_decoder = st;
        if (expect_it) begin
            e = '{pc: pc, rd: rd, data: data, st: st, exc: exc, tgt: tgt};
            q.push_back(e);
        end
        tick();
        is_empty_from_decoder = 1'b1;
        is_store_from_decoder = 1'b0;
    endtask

    task automatic wb(logic av, logic [31:0] apc, logic [31:0] ad,
                      logic mis, logic [31:0] tgt,
                      logic sv, logic [31:0] spc, logic [31:0] sd);
        is_finish_from_alu     = av;
        pc_from_alu            = apc;
        data_from_alu          = ad;
        is_mispredict_from_alu = mis;
        target_from_alu        = tgt;
        is_finish_from_slb     = sv;
        pc_from_slb            = spc;
        data_from_slb          = sd;
        tick();
        is_finish_from_alu     = 1'b0;
        is_mispredict_from_alu = 1'b0;
        is_finish_from_slb     = 1'b0;
    endtask

    task automatic alu(logic [31:0] pc, logic [31:0] d);
        wb(1'b1, pc, d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain(int remain, int bound);
        int n = 0;
        while (q.size() > remain && n < bound) begin
            tick();
            n++;
        end
        checks++;
        assert (q.size() <= remain)
        else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected %0d", q.size(), remain);
        end
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_commit", 32'(is_commit_to_rf), 32'h0);
        chk("rst_exc", 32'(is_exception_to_rf), 32'h0);
        chk("rst_pc", pc_to_rf, 32'h0);
        chk("rst_rd", 32'(rd_to_rf), 32'h0);
        chk("rst_data", data_to_rf, 32'h0);
        chk("rst_store", 32'(is_commit_store_to_slb), 32'h0);
        chk("rst_pc_slb", pc_to_slb, 32'h0);
        chk("rst_target", target_pc_to_if, 32'h0);
        chk("rst_full", 32'(is_full_to_decoder), 32'h0);
        rst = 1'b0;

        issue(32'h100, 5'd1, 1'b0, 32'h11, 1'b0, 32'h0, 1'b1);
        alu(32'h100, 32'h11);
        drain(0, 10);

        // Out-of-order finish, in-order retire
        issue(32'h0, 5'd1, 1'b0, 32'd5, 1'b0, 32'h0, 1'b1);
        issue(32'h4, 5'd2, 1'b0, 32'd7, 1'b0, 32'h0, 1'b1);
        alu(32'h4, 32'd7);
        alu(32'h0, 32'd5);
        drain(0, 10);

        // Fill, overflow, partial retire and wrap
        for (int i = 0; i < 16; i++)
            issue(32'h200 + 32'(4 * i), 5'(i + 1), 1'b0,
                  32'h1000 + 32'(i), 1'b0, 32'h0, 1'b1);
        chk("full_at_16", 32'(is_full_to_decoder), 32'h1);
        issue(32'h300, 5'd31, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("full_after_drop", 32'(is_full_to_decoder), 32'h1);
        alu(32'h300, 32'hdead);
        for (int i = 0; i < 4; i++)
            alu(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        drain(12, 20);
        chk("not_full", 32'(is_full_to_decoder), 32'h0);
        for (int i = 16; i < 20; i++)
            issue(32'h200 + 32'(4 * i), 5'(i + 1), 1'b0,
                  32'h1000 + 32'(i), 1'b0, 32'h0, 1'b1);
        for (int i = 19; i >= 4; i--)
            alu(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        drain(0, 40);

        // Mispredict at head flushes everything
        issue(32'h10, 5'd1, 1'b0, 32'h14, 1'b1, 32'h40, 1'b1);
        issue(32'h14, 5'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(32'h18, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        wb(1'b1, 32'h10, 32'h14, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        tick();
        chk("exc_pulse", 32'(is_exception_to_rf), 32'h1);
        issue(32'h50, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("exc_deassert", 32'(is_exception_to_rf), 32'h0);
        alu(32'h50, 32'h1);
        alu(32'h14, 32'h2);
        alu(32'h18, 32'h3);
        repeat (3) tick();
        chk("flush_empty_q", 32'(q.size()), 32'h0);

        // Duplicate tags retire oldest-first
        issue(32'h20, 5'd3, 1'b0, 32'hA, 1'b0, 32'h0, 1'b1);
        issue(32'h24, 5'd4, 1'b0, 32'hB, 1'b0, 32'h0, 1'b1);
        issue(32'h20, 5'd5, 1'b0, 32'hC, 1'b0, 32'h0, 1'b1);
        alu(32'h20, 32'hA);
        alu(32'h24, 32'hB);
        alu(32'h20, 32'hC);
        drain(0, 10);

        // SLB writebacks, store retire, ALU beats SLB on one entry
        issue(32'h30, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        issue(32'h34, 5'd6, 1'b0, 32'h55, 1'b0, 32'h0, 1'b1);
        issue(32'h38, 5'd9, 1'b0, 32'h99, 1'b0, 32'h0, 1'b1);
        issue(32'h3c, 5'd10, 1'b0, 32'hAA, 1'b0, 32'h0, 1'b1);
        wb(1'b1, 32'h38, 32'h99, 1'b0, 32'h0, 1'b1, 32'h34, 32'h55);
        wb(1'b1, 32'h3c, 32'hAA, 1'b0, 32'h0, 1'b1, 32'h3c, 32'hBB);
        wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h30, 32'h0);
        drain(0, 10);

        // rdy stall holds a pending commit
        issue(32'h60, 5'd7, 1'b0, 32'h77, 1'b0, 32'h0, 1'b1);
        issue(32'h64, 5'd8, 1'b0, 32'h88, 1'b0, 32'h0, 1'b1);
        alu(32'h60, 32'h77);
        rdy = 1'b0;
        alu(32'h64, 32'h88);
        rdy = 1'b1;
        alu(32'h64, 32'h88);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_commit", 32'(is_commit_to_rf), 32'h1);
            chk("stall_pc", pc_to_rf, 32'h60);
        end
        rdy = 1'b1;
        tick();
        chk("one_commit", 32'(q.size()), 32'h1);
        drain(0, 10);
        repeat (3) tick();
        chk("final_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
